if_fetch: RTL and testbench

//  Instruction-fetch stage directly downstream of the PC register. Takes the

---
 rtl/if_fetch.sv | 183 ++++++++++++++++++
 tb/tb_if_fetch.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// ----------------------------------------------------------------------------
// if_fetch
//   Instruction-fetch stage sitting right after the PC register. Launches one
//   instruction-memory read per instruction (never more than one in flight,
//   memory latency is variable), presents the fetch bundle {pc, instr, pc+4}
//   to decode through a valid/ready handshake, and tells the PC path when it
//   must hold. A redirect (flush) discards any in-flight or held fetch.
//
// Ports
//   clk          in   clock, all state updates on posedge
//   rst          in   synchronous active-high reset
//   i_pc         in   current PC from the PC register
//   flush        in   redirect from EX, kills the current fetch
//   imem_req     out  one-cycle read request strobe
//   imem_addr    out  read address, meaningful while imem_req=1
//   imem_rvalid  in   read data valid, at most one per request
//   imem_rdata   in   read data
//   o_valid      out  fetch bundle valid to decode
//   id_ready     in   decode accepts the bundle this cycle
//   o_pc         out  PC of the bundle
//   o_instr      out  fetched instruction (NOP when no valid fetch)
//   o_pc_next    out  o_pc + 4, wrapping modulo 2^ADDR_W
//   o_exc_adel   out  bundle carries a misaligned-PC fault
//   pc_hold      out  1 = PC path must not advance this cycle
// ----------------------------------------------------------------------------
module if_fetch #(
   parameter int                 ADDR_W  = 32,
   parameter int                 INSTR_W = 32,
   parameter logic [INSTR_W-1:0] NOP     = {INSTR_W{1'b0}}
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ADDR_W-1:0]  i_pc,
   input  logic               flush,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               o_valid,
   input  logic               id_ready,
   output logic [ADDR_W-1:0]  o_pc,
   output logic [INSTR_W-1:0] o_instr,
   output logic [ADDR_W-1:0]  o_pc_next,
   output logic               o_exc_adel,
   output logic               pc_hold
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;
   localparam logic [1:0] S_DROP = 2'd3;

   localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(3'd4);

   logic [1:0]         r_state;
   logic [ADDR_W-1:0]  r_req_pc;
   logic               r_valid;
   logic [ADDR_W-1:0]  r_pc;
   logic [INSTR_W-1:0] r_instr;
   logic [ADDR_W-1:0]  r_pc_next;
   logic               r_exc_adel;

   logic w_launch;
   logic w_aligned;
   logic w_issue;
   logic w_fault;

   // Launch decision: a slot opens in IDLE, or in HOLD when decode takes the
   // bundle. Reset and redirect both suppress the launch so the PC holds.
   always_comb begin
      w_launch  = 1'b0;
      w_aligned = (i_pc[1:0] == 2'b00);
      if (rst || flush) begin
         w_launch = 1'b0;
      end else if (r_state == S_IDLE) begin
         w_launch = 1'b1;
      end else if ((r_state == S_HOLD) && id_ready) begin
         w_launch = 1'b1;
      end else begin
         w_launch = 1'b0;
      end
      w_issue = w_launch && w_aligned;
      w_fault = w_launch && !w_aligned;
   end

   // Memory request and PC-hold strobes; a misaligned PC launches a fault
   // bundle instead of a read, which still lets the PC advance.
   always_comb begin
      imem_req  = w_issue;
      imem_addr = i_pc;
      pc_hold   = !w_launch;
   end

   // Fetch state machine and the registered bundle presented to decode.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_req_pc   <= {ADDR_W{1'b0}};
         r_valid    <= 1'b0;
         r_pc       <= {ADDR_W{1'b0}};
         r_instr    <= NOP;
         r_pc_next  <= {ADDR_W{1'b0}};
         r_exc_adel <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // Any rvalid seen here is an orphan from before reset: ignore it.
               if (w_issue) begin
                  r_req_pc <= i_pc;
                  r_state  <= S_WAIT;
               end else if (w_fault) begin
                  r_valid    <= 1'b1;
                  r_pc       <= i_pc;
                  r_instr    <= NOP;
                  r_pc_next  <= i_pc + PC_INC;
                  r_exc_adel <= 1'b1;
                  r_state    <= S_HOLD;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_WAIT: begin
               if (imem_rvalid && !flush) begin
                  r_valid    <= 1'b1;
                  r_pc       <= r_req_pc;
                  r_instr    <= imem_rdata;
                  r_pc_next  <= r_req_pc + PC_INC;
                  r_exc_adel <= 1'b0;
                  r_state    <= S_HOLD;
               end else if (flush && !imem_rvalid) begin
                  // Response still owed: wait for it so it cannot be mistaken
                  // for the answer to the next request.
                  r_state <= S_DROP;
               end else if (flush) begin
                  r_state <= S_IDLE;
               end else begin
                  r_state <= S_WAIT;
               end
            end
            S_HOLD: begin
               if (flush) begin
                  r_valid    <= 1'b0;
                  r_instr    <= NOP;
                  r_exc_adel <= 1'b0;
                  r_state    <= S_IDLE;
               end else if (w_issue) begin
                  r_valid    <= 1'b0;
                  r_instr    <= NOP;
                  r_exc_adel <= 1'b0;
                  r_req_pc   <= i_pc;
                  r_state    <= S_WAIT;
               end else if (w_fault) begin
                  r_valid    <= 1'b1;
                  r_pc       <= i_pc;
                  r_instr    <= NOP;
                  r_pc_next  <= i_pc + PC_INC;
                  r_exc_adel <= 1'b1;
                  r_state    <= S_HOLD;
               end else begin
                  r_state <= S_HOLD;
               end
            end
            S_DROP: begin
               if (imem_rvalid) begin
                  r_state <= S_IDLE;
               end else begin
                  r_state <= S_DROP;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_valid    = r_valid;
   assign o_pc       = r_pc;
   assign o_instr    = r_instr;
   assign o_pc_next  = r_pc_next;
   assign o_exc_adel = r_exc_adel;

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

   logic        clk;
   logic        rst;
   logic [31:0] i_pc;
   logic        flush;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        o_valid;
   logic        id_ready;
   logic [31:0] o_pc;
   logic [31:0] o_instr;
   logic [31:0] o_pc_next;
   logic        o_exc_adel;
   logic        pc_hold;

   int tests;
   int fails;

   if_fetch #(.ADDR_W(32), .INSTR_W(32), .NOP(32'h0)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_pc        (i_pc),
      .flush       (flush),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .o_valid     (o_valid),
      .id_ready    (id_ready),
      .o_pc        (o_pc),
      .o_instr     (o_instr),
      .o_pc_next   (o_pc_next),
      .o_exc_adel  (o_exc_adel),
      .pc_hold     (pc_hold)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change on the falling edge; returns at a falling edge with the
   // design in IDLE and rst still high.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; flush = 1'b0; imem_rvalid = 1'b0; id_ready = 1'b0;
      imem_rdata = 32'h0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      #1;
      tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b exp 0", imem_req); end
      tests++; if (pc_hold !== 1'b1) begin fails++; $display("FAIL rst_hold: got %b exp 1", pc_hold); end
      tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b exp 0", o_valid); end
      tests++; if (o_instr !== 32'h0) begin fails++; $display("FAIL rst_instr: got %h exp 0", o_instr); end
      tests++; if (o_pc !== 32'h0 || o_pc_next !== 32'h0) begin fails++; $display("FAIL rst_pc: got %h/%h exp 0/0", o_pc, o_pc_next); end
      tests++; if (o_exc_adel !== 1'b0) begin fails++; $display("FAIL rst_exc: got %b exp 0", o_exc_adel); end
   endtask

   task automatic test_basic_fetch();
      do_reset();
      rst = 1'b0; i_pc = 32'h0040_0000; #1;
      tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000) begin fails++; $display("FAIL basic_req: got %b/%h exp 1/00400000", imem_req, imem_addr); end
      tests++; if (pc_hold !== 1'b0) begin fails++; $display("FAIL basic_hold: got %b exp 0", pc_hold); end
      @(negedge clk);
      imem_rvalid = 1'b1; imem_rdata = 32'h2402_0005; #1;
      tests++; if (imem_req !== 1'b0 || pc_hold !== 1'b1 || o_valid !== 1'b0) begin fails++; $display("FAIL basic_wait: got req=%b hold=%b valid=%b exp 0/1/0", imem_req, pc_hold, o_valid); end
      @(negedge clk);
      imem_rvalid = 1'b0; #1;
      tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %b exp 1", o_valid); end
      tests++; if (o_pc !== 32'h0040_0000 || o_instr !== 32'h2402_0005) begin fails++; $display("FAIL basic_bundle: got %h/%h exp 00400000/24020005", o_pc, o_instr); end
      tests++; if (o_pc_next !== 32'h0040_0004 || o_exc_adel !== 1'b0) begin fails++; $display("FAIL basic_next: got %h/%b exp 00400004/0", o_pc_next, o_exc_adel); end
   endtask

   // Continues from the HOLD state left by test_basic_fetch.
   task automatic test_hold_stall();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         i_pc = 32'h0040_0004; #1;
         tests++;
         if (o_valid !== 1'b1 || o_instr !== 32'h2402_0005 || o_pc !== 32'h0040_0000 || pc_hold !== 1'b1 || imem_req !== 1'b0) begin
            fails++;
            $display("FAIL stall_%0d: got valid=%b instr=%h pc=%h hold=%b req=%b exp 1/24020005/00400000/1/0", i, o_valid, o_instr, o_pc, pc_hold, imem_req);
         end
      end
      @(negedge clk);
      id_ready = 1'b1; #1;
      tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0004 || pc_hold !== 1'b0) begin fails++; $display("FAIL consume_req: got %b/%h/%b exp 1/00400004/0", imem_req, imem_addr, pc_hold); end
      @(negedge clk);
      id_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h8C43_0000; #1;
      tests++; if (o_valid !== 1'b0 || o_instr !== 32'h0) begin fails++; $display("FAIL consume_clear: got %b/%h exp 0/00000000", o_valid, o_instr); end
      @(negedge clk);
      imem_rvalid = 1'b0; #1;
      tests++; if (o_valid !== 1'b1 || o_pc !== 32'h0040_0004 || o_instr !== 32'h8C43_0000) begin fails++; $display("FAIL second_bundle: got %b/%h/%h exp 1/00400004/8c430000", o_valid, o_pc, o_instr); end
   endtask

   task automatic test_flush_drop();
      do_reset();
      rst = 1'b0; i_pc = 32'h0040_0100; #1;
      tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL flush_req: got %b exp 1", imem_req); end
      @(negedge clk);
      flush = 1'b1; #1;
      tests++; if (imem_req !== 1'b0 || pc_hold !== 1'b1) begin fails++; $display("FAIL flush_wait: got %b/%b exp 0/1", imem_req, pc_hold); end
      @(negedge clk);
      flush = 1'b0; i_pc = 32'h0050_0000; #1;
      tests++; if (imem_req !== 1'b0 || o_valid !== 1'b0) begin fails++; $display("FAIL drop_1: got req=%b valid=%b exp 0/0", imem_req, o_valid); end
      @(negedge clk); #1;
      tests++; if (imem_req !== 1'b0 || pc_hold !== 1'b1) begin fails++; $display("FAIL drop_2: got req=%b hold=%b exp 0/1", imem_req, pc_hold); end
      @(negedge clk);
      imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
      tests++; if (imem_req !== 1'b0 || o_valid !== 1'b0) begin fails++; $display("FAIL drop_resp: got req=%b valid=%b exp 0/0", imem_req, o_valid); end
      @(negedge clk);
      imem_rvalid = 1'b0; #1;
      tests++; if (o_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0050_0000) begin fails++; $display("FAIL redirect_req: got valid=%b req=%b addr=%h exp 0/1/00500000", o_valid, imem_req, imem_addr); end
      @(negedge clk);
      imem_rvalid = 1'b1; imem_rdata = 32'h1111_2222; #1;
      @(negedge clk);
      imem_rvalid = 1'b0; #1;
      tests++; if (o_valid !== 1'b1 || o_pc !== 32'h0050_0000 || o_instr !== 32'h1111_2222) begin fails++; $display("FAIL redirect_bundle: got %b/%h/%h exp 1/00500000/11112222", o_valid, o_pc, o_instr); end
   endtask

   task automatic test_misaligned();
      do_reset();
      rst = 1'b0; i_pc = 32'h0040_0002; #1;
      tests++; if (imem_req !== 1'b0 || pc_hold !== 1'b0) begin fails++; $display("FAIL adel_launch: got req=%b hold=%b exp 0/0", imem_req, pc_hold); end
      @(negedge clk);
      i_pc = 32'h0040_0006; #1;
      tests++; if (o_valid !== 1'b1 || o_exc_adel !== 1'b1 || o_instr !== 32'h0) begin fails++; $display("FAIL adel_bundle: got %b/%b/%h exp 1/1/00000000", o_valid, o_exc_adel, o_instr); end
      tests++; if (o_pc !== 32'h0040_0002 || o_pc_next !== 32'h0040_0006) begin fails++; $display("FAIL adel_pc: got %h/%h exp 00400002/00400006", o_pc, o_pc_next); end
   endtask

   task automatic test_wrap();
      do_reset();
      rst = 1'b0; i_pc = 32'hFFFF_FFFC; #1;
      tests++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_req: got %b/%h exp 1/fffffffc", imem_req, imem_addr); end
      @(negedge clk);
      imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013; #1;
      @(negedge clk);
      imem_rvalid = 1'b0; #1;
      tests++; if (o_pc !== 32'hFFFF_FFFC || o_pc_next !== 32'h0000_0000 || o_exc_adel !== 1'b0) begin fails++; $display("FAIL wrap_next: got %h/%h/%b exp fffffffc/00000000/0", o_pc, o_pc_next, o_exc_adel); end
   endtask

   task automatic test_reset_in_wait();
      do_reset();
      rst = 1'b0; i_pc = 32'h0040_0000; #1;
      @(negedge clk);
      rst = 1'b1; #1;
      @(negedge clk);
      rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0; i_pc = 32'h0040_0200; #1;
      tests++; if (o_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0040_0200) begin fails++; $display("FAIL rstwait_idle: got valid=%b req=%b addr=%h exp 0/1/00400200", o_valid, imem_req, imem_addr); end
      @(negedge clk);
      imem_rvalid = 1'b0; #1;
      tests++; if (o_valid !== 1'b0 || imem_req !== 1'b0) begin fails++; $display("FAIL rstwait_late: got valid=%b req=%b exp 0/0", o_valid, imem_req); end
      @(negedge clk);
      imem_rvalid = 1'b1; imem_rdata = 32'h3333_4444; #1;
      @(negedge clk);
      imem_rvalid = 1'b0; #1;
      tests++; if (o_valid !== 1'b1 || o_pc !== 32'h0040_0200 || o_instr !== 32'h3333_4444) begin fails++; $display("FAIL rstwait_bundle: got %b/%h/%h exp 1/00400200/33334444", o_valid, o_pc, o_instr); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      rst = 1'b0; id_ready = 1'b1; i_pc = 32'h0000_1000; #1;
      @(negedge clk);
      imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_0001; #1;
      @(negedge clk);
      imem_rvalid = 1'b0; i_pc = 32'h0000_1004; #1;
      tests++; if (o_valid !== 1'b1 || o_pc !== 32'h0000_1000 || o_instr !== 32'hAAAA_0001) begin fails++; $display("FAIL b2b_first: got %b/%h/%h exp 1/00001000/aaaa0001", o_valid, o_pc, o_instr); end
      tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_1004 || pc_hold !== 1'b0) begin fails++; $display("FAIL b2b_req: got %b/%h/%b exp 1/00001004/0", imem_req, imem_addr, pc_hold); end
      @(negedge clk);
      imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_0002; #1;
      tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL b2b_gap: got %b exp 0", o_valid); end
      @(negedge clk);
      imem_rvalid = 1'b0; i_pc = 32'h0000_1008; flush = 1'b1; #1;
      tests++; if (o_valid !== 1'b1 || o_pc !== 32'h0000_1004 || o_instr !== 32'hAAAA_0002) begin fails++; $display("FAIL b2b_second: got %b/%h/%h exp 1/00001004/aaaa0002", o_valid, o_pc, o_instr); end
      tests++; if (imem_req !== 1'b0 || pc_hold !== 1'b1) begin fails++; $display("FAIL hold_flush_req: got %b/%b exp 0/1", imem_req, pc_hold); end
      @(negedge clk);
      flush = 1'b0; id_ready = 1'b0; #1;
      tests++; if (o_valid !== 1'b0 || o_instr !== 32'h0) begin fails++; $display("FAIL hold_flush_clear: got %b/%h exp 0/00000000", o_valid, o_instr); end
   endtask

   initial begin
      tests = 0; fails = 0;
      rst = 1'b1; i_pc = 32'h0; flush = 1'b0; imem_rvalid = 1'b0;
      imem_rdata = 32'h0; id_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic_fetch();
      test_hold_stall();
      test_flush_drop();
      test_misaligned();
      test_wrap();
      test_reset_in_wait();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
